// File: rtl/mcu_xbus_arbiter.sv
// mcu_xbus_arbiter
//   8051 external-bus arbiter/decoder. Code and data strobes are served one at
//   a time. Each access is routed to the program/data SRAM, to the MIPI APB
//   bridge, or to the internal register bank. The register bank holds:
//     - control registers
//     - synchronised status registers
//     - a W1C error register
//     - a byte packer that feeds a command FIFO
//   Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a bridge access
//   that gets no br_ack within TIMEOUT_CYC cycles is abandoned. That access
//   returns 8'hFF and sets error bit 0.
// Ports
//   cpuclk, rstn                 clock, asynchronous active-low reset
//   memaddr/memdatao             core address / write data
//   memrd/memwr                  data strobes, held by the core until memack
//   mempsrd/mempswr              code strobes, held by the core until mempsack
//   memack/mempsack/memdatai     1-cycle acks and the read data valid with them
//   ram_*                        SRAM strobes, address, write/read data, ack
//   br_*                         bridge strobes, read data, ack
//   ctrl_o                       control registers, reg k at [8k+7:8k]
//   stat_i                       asynchronous status inputs
//   pkt_wdata/pkt_wen/pkt_full   packed FIFO word, write pulse, FIFO full
module mcu_xbus_arbiter #(
  parameter int NUM_CTRL    = 4,
  parameter int NUM_STAT    = 9,
  parameter int PACK_BYTES  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    cpuclk,
  input  logic                    rstn,
  input  logic [22:0]             memaddr,
  input  logic [7:0]              memdatao,
  input  logic                    memrd,
  input  logic                    memwr,
  input  logic                    mempsrd,
  input  logic                    mempswr,
  output logic                    memack,
  output logic                    mempsack,
  output logic [7:0]              memdatai,
  output logic                    ram_rd,
  output logic                    ram_wr,
  output logic [22:0]             ram_addr,
  output logic [7:0]              ram_wdata,
  input  logic [7:0]              ram_rdata,
  input  logic                    ram_ack,
  output logic                    br_rd,
  output logic                    br_wr,
  input  logic [7:0]              br_rdata,
  input  logic                    br_ack,
  output logic [NUM_CTRL*8-1:0]   ctrl_o,
  input  logic [NUM_STAT*8-1:0]   stat_i,
  output logic [PACK_BYTES*8-1:0] pkt_wdata,
  output logic                    pkt_wen,
  input  logic                    pkt_full
);
  localparam int CNT_W = $clog2(PACK_BYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_RAM, S_BR, S_REG, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    acc_data_q, acc_wr_q;
  logic [22:0]             acc_addr_q;
  logic [7:0]              acc_wdata_q;
  logic                    data_req, code_req, load_acc, reg_wr, timeout;
  logic                    memack_d, mempsack_d;
  logic [7:0]              rdata_d, reg_rdata, reg_off;
  logic [NUM_CTRL*8-1:0]   ctrl_q;
  logic [NUM_STAT*8-1:0]   stat_s1, stat_s2;
  logic [1:0]              err_q, err_set, err_clr;
  logic [CNT_W-1:0]        cnt_q;
  logic [PACK_BYTES*8-1:0] buf_q;
  logic                    emit_q;

  assign data_req = memrd | memwr;
  assign code_req = mempsrd | mempswr;
  assign reg_off  = memaddr[7:0];

  // Strobes follow the state. Leaving RAM/BR drops them in the same cycle as the ack.
  assign ram_rd    = (state_q == S_RAM) & ~acc_wr_q;
  assign ram_wr    = (state_q == S_RAM) &  acc_wr_q;
  assign br_rd     = (state_q == S_BR)  & ~acc_wr_q;
  assign br_wr     = (state_q == S_BR)  &  acc_wr_q;
  assign ram_addr  = acc_addr_q;
  assign ram_wdata = acc_wdata_q;
  assign ctrl_o    = ctrl_q;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn)                           to_cnt_q <= '0;
    else if (state_q == S_BR && !br_ack) to_cnt_q <= to_cnt_q + 1'b1;
    else                                 to_cnt_q <= '0;
  end

  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Register-bank read mux. Unmapped offsets read 0.
  always_comb begin
    reg_rdata = 8'h00;
    if (reg_off == 8'h01) reg_rdata = 8'(cnt_q);
    if (reg_off == 8'h02) reg_rdata = {6'b0, err_q};
    for (int k = 0; k < NUM_CTRL; k++)
      if (reg_off == 8'(16 + k)) reg_rdata = ctrl_q[8*k +: 8];
    for (int k = 0; k < NUM_STAT; k++)
      if (reg_off == 8'(64 + k)) reg_rdata = stat_s2[8*k +: 8];
  end

  // Next state and registered ack/data. Data strobes win over code strobes.
  always_comb begin
    state_d    = state_q;
    memack_d   = 1'b0;
    mempsack_d = 1'b0;
    rdata_d    = memdatai;
    load_acc   = 1'b0;
    reg_wr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          load_acc = 1'b1;
          if (!memaddr[17])     state_d = S_RAM;
          else if (!memaddr[11]) state_d = S_BR;
          else begin
            // The register access completes at this edge; REG is the ack cycle.
            state_d  = S_REG;
            memack_d = 1'b1;
            rdata_d  = memwr ? 8'h00 : reg_rdata;
            reg_wr   = memwr;
          end
        end else if (code_req) begin
          load_acc = 1'b1;
          state_d  = S_RAM;
        end
      end
      S_RAM: begin
        if (ram_ack) begin
          state_d    = S_DONE;
          rdata_d    = acc_wr_q ? 8'h00 : ram_rdata;
          memack_d   = acc_data_q;
          mempsack_d = ~acc_data_q;
        end
      end
      S_BR: begin
        if (br_ack) begin
          state_d  = S_DONE;
          memack_d = 1'b1;
          rdata_d  = acc_wr_q ? 8'h00 : br_rdata;
        end else if (timeout) begin
          state_d  = S_DONE;
          memack_d = 1'b1;
          rdata_d  = 8'hFF;
        end
      end
      S_REG: state_d = S_DONE;
      S_DONE: begin
        // Wait for the served strobe to drop so that a held strobe is not served twice.
        if (acc_data_q ? !data_req : !code_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus FSM and access capture
  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      memack      <= 1'b0;
      mempsack    <= 1'b0;
      memdatai    <= 8'h00;
      acc_data_q  <= 1'b0;
      acc_wr_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      memack   <= memack_d;
      mempsack <= mempsack_d;
      memdatai <= rdata_d;
      if (load_acc) begin
        acc_data_q  <= data_req;
        acc_wr_q    <= data_req ? memwr : mempswr;
        acc_addr_q  <= memaddr;
        acc_wdata_q <= memdatao;
      end
    end
  end

  // Status synchroniser
  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn) begin
      stat_s1 <= '0;
      stat_s2 <= '0;
    end else begin
      stat_s1 <= stat_i;
      stat_s2 <= stat_s1;
    end
  end

  // A new error event beats a W1C clear in the same cycle.
  assign err_set = {emit_q & pkt_full, (state_q == S_BR) & ~br_ack & timeout};
  assign err_clr = (reg_wr && reg_off == 8'h02) ? memdatao[1:0] : 2'b00;

  // Register bank and packer. emit_q moves the FIFO write one cycle past the ack.
  always_ff @(posedge cpuclk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q    <= '0;
      err_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      emit_q    <= 1'b0;
      pkt_wen   <= 1'b0;
      pkt_wdata <= '0;
    end else begin
      pkt_wen <= 1'b0;
      err_q   <= (err_q & ~err_clr) | err_set;
      if (emit_q) begin
        emit_q <= 1'b0;
        cnt_q  <= '0;
        buf_q  <= '0;
        if (!pkt_full) begin
          pkt_wen   <= 1'b1;
          pkt_wdata <= buf_q;
        end
      end
      if (reg_wr) begin
        if (reg_off == 8'h00) begin
          for (int k = 0; k < PACK_BYTES; k++)
            if (cnt_q == CNT_W'(k)) buf_q[8*k +: 8] <= memdatao;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PACK_BYTES - 1)) emit_q <= 1'b1;
        end
        if (reg_off == 8'h01) begin
          if (memdatao[1]) begin
            cnt_q <= '0;
            buf_q <= '0;
          end else if (memdatao[0] && cnt_q != '0) begin
            emit_q <= 1'b1;
          end
        end
        for (int k = 0; k < NUM_CTRL; k++)
          if (reg_off == 8'(16 + k)) ctrl_q[8*k +: 8] <= memdatao;
      end
    end
  end

endmodule

// File: tb/tb_mcu_xbus_arbiter.sv
module tb_mcu_xbus_arbiter;
  localparam int NUM_CTRL    = 4;
  localparam int NUM_STAT    = 9;
  localparam int PACK_BYTES  = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                    cpuclk = 1'b0;
  logic                    rstn;
  logic [22:0]             memaddr;
  logic [7:0]              memdatao;
  logic                    memrd, memwr, mempsrd, mempswr;
  logic                    memack, mempsack;
  logic [7:0]              memdatai;
  logic                    ram_rd, ram_wr;
  logic [22:0]             ram_addr;
  logic [7:0]              ram_wdata, ram_rdata;
  logic                    ram_ack;
  logic                    br_rd, br_wr;
  logic [7:0]              br_rdata;
  logic                    br_ack;
  logic [NUM_CTRL*8-1:0]   ctrl_o;
  logic [NUM_STAT*8-1:0]   stat_i;
  logic [PACK_BYTES*8-1:0] pkt_wdata;
  logic                    pkt_wen;
  logic                    pkt_full;

  mcu_xbus_arbiter #(
    .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT),
    .PACK_BYTES(PACK_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .cpuclk(cpuclk), .rstn(rstn), .memaddr(memaddr), .memdatao(memdatao),
    .memrd(memrd), .memwr(memwr), .mempsrd(mempsrd), .mempswr(mempswr),
    .memack(memack), .mempsack(mempsack), .memdatai(memdatai),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .br_rd(br_rd), .br_wr(br_wr), .br_rdata(br_rdata), .br_ack(br_ack),
    .ctrl_o(ctrl_o), .stat_i(stat_i),
    .pkt_wdata(pkt_wdata), .pkt_wen(pkt_wen), .pkt_full(pkt_full)
  );

  always #5 cpuclk = ~cpuclk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_ack_cyc = -10;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, req);
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit code; bit chk; logic [7:0] d; } exp_t;
  exp_t                    exp_q[$];
  logic [PACK_BYTES*8-1:0] exp_pkt[$];
  logic [7:0]              ref_mem[logic [22:0]];
  logic [7:0]              sram[logic [22:0]];
  logic [7:0]              pq[$];
  logic [7:0]              ctrl_m[NUM_CTRL];
  logic [7:0]              stat_v[NUM_STAT];
  logic [1:0]              err_m;

  function automatic logic [22:0] reg_a(input logic [7:0] off);
    logic [22:0] a = '0;
    a[17] = 1'b1; a[11] = 1'b1; a[7:0] = off;
    return a;
  endfunction

  function automatic logic [7:0] br_val(input logic [22:0] a);
    return a[7:0] ^ a[10:3] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] model_read(input logic [22:0] a);
    logic [7:0] off = a[7:0];
    if (!a[17]) return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    if (!a[11]) return br_val(a);
    if (off == 8'h01) return 8'(pq.size());
    if (off == 8'h02) return {6'b0, err_m};
    if (off >= 8'h10 && int'(off) < 16 + NUM_CTRL) return ctrl_m[off - 8'h10];
    if (off >= 8'h40 && int'(off) < 64 + NUM_STAT) return stat_v[off - 8'h40];
    return 8'h00;
  endfunction

  task automatic emit_word();
    logic [PACK_BYTES*8-1:0] w = '0;
    for (int i = 0; i < pq.size(); i++) w[8*i +: 8] = pq[i];
    if (pkt_full) err_m[1] = 1'b1;
    else          exp_pkt.push_back(w);
    pq.delete();
  endtask

  task automatic model_write(input logic [22:0] a, input logic [7:0] wd);
    logic [7:0] off = a[7:0];
    if (!a[17]) begin ref_mem[a] = wd; return; end
    if (!a[11]) return;
    if (off == 8'h00) begin
      pq.push_back(wd);
      if (pq.size() == PACK_BYTES) emit_word();
    end else if (off == 8'h01) begin
      if (wd[1]) pq.delete();
      else if (wd[0] && pq.size() > 0) emit_word();
    end else if (off == 8'h02) begin
      err_m = err_m & ~wd[1:0];
    end else if (off >= 8'h10 && int'(off) < 16 + NUM_CTRL) begin
      ctrl_m[off - 8'h10] = wd;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CTRL; k++) ctrl_m[k] = 8'h00;
    pq.delete();
    err_m = 2'b00;
  endtask

  // ---------------- monitors ----------------
  always @(posedge cpuclk) cyc++;

  always @(negedge cpuclk) begin : ack_mon
    exp_t e;
    if (rstn && (memack || mempsack)) begin
      last_ack_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_ack: memack=%0b mempsack=%0b with nothing pending", memack, mempsack);
      end else begin
        e = exp_q.pop_front();
        check("ack_kind(psack)", {63'b0, mempsack}, {63'b0, e.code});
        if (e.chk) check("memdatai", {56'b0, memdatai}, {56'b0, e.d});
      end
    end
  end

  always @(negedge cpuclk) begin
    if (rstn && pkt_wen) begin
      if (exp_pkt.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pkt: pkt_wdata=%0h with none expected", pkt_wdata);
      end else begin
        check("pkt_wdata", 64'(pkt_wdata), 64'(exp_pkt.pop_front()));
      end
      check("pkt_wen_timing", 64'(cyc), 64'(last_ack_cyc + 1));
    end
  end

  // ---------------- SRAM and bridge responders ----------------
  int ram_dly = -1, ram_seen = 0, ram_lim = 0;
  int br_seen = 0, br_lim = 0;
  bit br_en = 1'b1;

  always @(negedge cpuclk) begin
    if (!rstn) begin ram_ack = 1'b0; ram_seen = 0; end
    else if (ram_ack) ram_ack = 1'b0;
    else if (ram_rd || ram_wr) begin
      if (ram_seen == 0) ram_lim = (ram_dly >= 0) ? ram_dly : int'($urandom_range(0, 3));
      if (ram_seen >= ram_lim) begin
        ram_ack = 1'b1; ram_seen = 0;
        if (ram_wr) sram[ram_addr] = ram_wdata;
        else        ram_rdata = sram.exists(ram_addr) ? sram[ram_addr] : 8'h00;
      end else ram_seen++;
    end
  end

  always @(negedge cpuclk) begin
    if (!rstn) begin br_ack = 1'b0; br_seen = 0; end
    else if (br_ack) br_ack = 1'b0;
    else if ((br_rd || br_wr) && br_en) begin
      if (br_seen == 0) br_lim = int'($urandom_range(0, 4));
      if (br_seen >= br_lim) begin
        br_ack = 1'b1; br_seen = 0; br_rdata = br_val(memaddr);
      end else br_seen++;
    end
  end

  // ---------------- bus master ----------------
  task automatic data_acc(input bit wr, input logic [22:0] a, input logic [7:0] wd,
                          input bit push, output int lat);
    exp_t e;
    if (push) begin
      e.code = 1'b0; e.chk = !wr; e.d = wr ? 8'h00 : model_read(a);
      exp_q.push_back(e);
      if (wr) model_write(a, wd);
    end
    @(negedge cpuclk);
    memaddr = a; memdatao = wd; memwr = wr; memrd = !wr;
    lat = 0;
    do begin @(negedge cpuclk); lat++; end while (!memack && lat < 300);
    if (!memack) begin
      n_chk++;
      $display("FAIL data_ack_timeout: no memack after %0d cycles, addr %0h", lat, a);
    end
    memrd = 1'b0; memwr = 1'b0;
    @(negedge cpuclk);
  endtask

  task automatic code_acc(input bit wr, input logic [22:0] a, input logic [7:0] wd,
                          input bit push, output int lat);
    exp_t e;
    if (push) begin
      e.code = 1'b1; e.chk = !wr; e.d = wr ? 8'h00 : model_read(a);
      exp_q.push_back(e);
      if (wr) ref_mem[a] = wd;
    end
    @(negedge cpuclk);
    memaddr = a; memdatao = wd; mempswr = wr; mempsrd = !wr;
    lat = 0;
    do begin @(negedge cpuclk); lat++; end while (!mempsack && lat < 300);
    if (!mempsack) begin
      n_chk++;
      $display("FAIL code_ack_timeout: no mempsack after %0d cycles, addr %0h", lat, a);
    end
    mempsrd = 1'b0; mempswr = 1'b0;
    @(negedge cpuclk);
  endtask

  function automatic logic [7:0] rand_off();
    case ($urandom_range(0, 8))
      0, 1:    return 8'h00;
      2:       return 8'h01;
      3:       return 8'h02;
      4:       return 8'(16 + $urandom_range(0, NUM_CTRL - 1));
      5:       return 8'(64 + $urandom_range(0, NUM_STAT - 1));
      6:       return 8'h05;
      7:       return 8'(16 + NUM_CTRL);
      default: return 8'(64 + NUM_STAT);
    endcase
  endfunction

  task automatic check_ctrl(input string nm);
    logic [NUM_CTRL*8-1:0] w;
    for (int k = 0; k < NUM_CTRL; k++) w[8*k +: 8] = ctrl_m[k];
    check(nm, 64'(ctrl_o), 64'(w));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, lat2, hold;
    bit saw_ack;
    logic [7:0] off, wd;
    logic [22:0] a;
    exp_t e;

    rstn = 1'b0; memaddr = '0; memdatao = '0;
    memrd = 0; memwr = 0; mempsrd = 0; mempswr = 0;
    ram_rdata = '0; ram_ack = 0; br_rdata = '0; br_ack = 0; pkt_full = 0;
    for (int k = 0; k < NUM_STAT; k++) begin
      stat_v[k] = 8'($urandom_range(0, 255));
      stat_i[8*k +: 8] = stat_v[k];
    end
    model_reset();
    repeat (3) @(negedge cpuclk);
    check("rst_acks", {62'b0, memack, mempsack}, 64'd0);
    check("rst_strobes", {60'b0, ram_rd, ram_wr, br_rd, br_wr}, 64'd0);
    check("rst_memdatai", 64'(memdatai), 64'd0);
    check("rst_ctrl_o", 64'(ctrl_o), 64'd0);
    check("rst_pkt", {31'b0, pkt_wen, pkt_wdata}, 64'd0);
    rstn = 1'b1;
    repeat (4) @(negedge cpuclk);

    // control register write/read with single-cycle reg latency
    data_acc(1, reg_a(8'h10), 8'hA5, 1, lat);
    check("t1_wr_latency", 64'(lat), 64'd1);
    check("t1_ctrl0", 64'(ctrl_o[7:0]), 64'hA5);
    data_acc(0, reg_a(8'h10), 8'h00, 1, lat);
    check("t1_rd_latency", 64'(lat), 64'd1);

    // full word packing
    data_acc(1, reg_a(8'h00), 8'h11, 1, lat);
    data_acc(1, reg_a(8'h00), 8'h22, 1, lat);
    data_acc(1, reg_a(8'h00), 8'h33, 1, lat);
    data_acc(1, reg_a(8'h00), 8'h44, 1, lat);
    data_acc(0, reg_a(8'h01), 8'h00, 1, lat);
    check("t2_pkt_emitted", 64'(exp_pkt.size()), 64'd0);

    // flush, overflow, W1C
    data_acc(1, reg_a(8'h00), 8'h11, 1, lat);
    data_acc(1, reg_a(8'h00), 8'h22, 1, lat);
    data_acc(1, reg_a(8'h01), 8'h01, 1, lat);
    data_acc(0, reg_a(8'h01), 8'h00, 1, lat);
    check("t3_flush_emitted", 64'(exp_pkt.size()), 64'd0);
    pkt_full = 1'b1;
    for (int i = 0; i < PACK_BYTES; i++) data_acc(1, reg_a(8'h00), 8'(8'h50 + i), 1, lat);
    data_acc(0, reg_a(8'h02), 8'h00, 1, lat);
    pkt_full = 1'b0;
    data_acc(1, reg_a(8'h02), 8'h02, 1, lat);
    data_acc(0, reg_a(8'h02), 8'h00, 1, lat);
    data_acc(1, reg_a(8'h00), 8'h99, 1, lat);
    data_acc(1, reg_a(8'h01), 8'h03, 1, lat);
    data_acc(0, reg_a(8'h01), 8'h00, 1, lat);

    // simultaneous code and data strobes to SRAM
    data_acc(1, 23'h00055, 8'h77, 1, lat);
    ram_dly = 2;
    e.code = 1'b0; e.chk = 1'b1; e.d = model_read(23'h00055); exp_q.push_back(e);
    e.code = 1'b1; exp_q.push_back(e);
    fork
      data_acc(0, 23'h00055, 8'h00, 0, lat);
      code_acc(0, 23'h00055, 8'h00, 0, lat2);
    join
    check("t4_code_after_data", 64'(lat2 > lat), 64'd1);
    ram_dly = -1;

    // randomized traffic
    for (int i = 0; i < 160; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          off = rand_off();
          wd = (off == 8'h01 || off == 8'h02) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
          data_acc(1'($urandom_range(0, 1)), reg_a(off), wd, 1, lat);
          check("rand_reg_latency", 64'(lat), 64'd1);
        end
        2: data_acc(1'($urandom_range(0, 1)), 23'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), 1, lat);
        3: data_acc(1'($urandom_range(0, 1)), 23'h20000 | 23'($urandom_range(0, 2047)),
                    8'($urandom_range(0, 255)), 1, lat);
        4: code_acc(1'($urandom_range(0, 1)), 23'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), 1, lat);
        default: pkt_full = ($urandom_range(0, 3) == 0);
      endcase
    end
    pkt_full = 1'b0;
    repeat (2) @(negedge cpuclk);
    check_ctrl("rand_ctrl_o");
    check("rand_pkt_drained", 64'(exp_pkt.size()), 64'd0);

`ifdef BUS_TIMEOUT_EN
    // bridge timeout
    br_en = 1'b0;
    e.code = 1'b0; e.chk = 1'b1; e.d = 8'hFF; exp_q.push_back(e);
    err_m[0] = 1'b1;
    data_acc(0, 23'h20123, 8'h00, 0, lat);
    check("t5_timeout_latency", 64'(lat), 64'(TIMEOUT_CYC + 1));
    br_en = 1'b1;
    data_acc(0, reg_a(8'h02), 8'h00, 1, lat);
    data_acc(1, reg_a(8'h02), 8'h01, 1, lat);
`endif

    // reset during a bridge wait
    data_acc(1, reg_a(8'h10), 8'h5A, 1, lat);
    data_acc(1, reg_a(8'h01), 8'h02, 1, lat);
    data_acc(1, reg_a(8'h00), 8'hC3, 1, lat);
    data_acc(0, reg_a(8'h01), 8'h00, 1, lat);
    br_en = 1'b0;
    hold = 10;
`ifndef BUS_TIMEOUT_EN
    hold = 40;
`endif
    @(negedge cpuclk);
    memaddr = 23'h20040; memrd = 1'b1;
    saw_ack = 1'b0;
    repeat (hold) begin
      @(negedge cpuclk);
      if (memack) saw_ack = 1'b1;
    end
    check("t6_no_ack_while_waiting", {63'b0, saw_ack}, 64'd0);
    check("t6_br_rd_before_rst", {63'b0, br_rd}, 64'd1);
    rstn = 1'b0;
    #1;
    check("t6_br_rd_in_rst", {63'b0, br_rd}, 64'd0);
    check("t6_memack_in_rst", {63'b0, memack}, 64'd0);
    check("t6_ctrl_in_rst", 64'(ctrl_o), 64'd0);
    memrd = 1'b0;
    model_reset();
    @(negedge cpuclk);
    rstn = 1'b1;
    br_en = 1'b1;
    repeat (3) @(negedge cpuclk);
    data_acc(0, reg_a(8'h01), 8'h00, 1, lat);
    data_acc(0, reg_a(8'h10), 8'h00, 1, lat);
    a = reg_a(8'h40);
    data_acc(0, a, 8'h00, 1, lat);

    repeat (4) @(negedge cpuclk);
    check("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("end_pkt_q_empty", 64'(exp_pkt.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
